// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory access (M) stage.
// Holds the memory op encodings, exception codes, the M-stage payload
// struct and small op-classification helpers.
package dm_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned REGW = 5;
  localparam int unsigned EXCW = 5;
  localparam int unsigned BEW  = XLEN / 8;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 4'd0,
    OP_ALU = 4'd1,
    OP_LW  = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LB  = 4'd5,
    OP_LBU = 4'd6,
    OP_SW  = 4'd7,
    OP_SH  = 4'd8,
    OP_SB  = 4'd9
  } dm_op_e;

  localparam logic [EXCW-1:0] EXC_NONE = 5'd0;
  localparam logic [EXCW-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXCW-1:0] EXC_ADES = 5'd5;

  // Instruction payload held by the M stage register.
  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rt;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] pc;
  } m_stage_t;

  function automatic logic op_is_load(logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic op_is_store(logic [OPW-1:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0.
  function automatic logic addr_misaligned(logic [OPW-1:0] op, logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_ext.sv
// dm_ext: load data extraction and sign/zero extension (combinational).
// Ports:
//   op_i    - memory op code of the instruction in M
//   addr_i  - low two address bits (lane select)
//   rdata_i - word read from data memory
//   data_o  - extended load value (0 for non-load ops)
module dm_ext
  import dm_pkg::*;
(
  input  logic [OPW-1:0]  op_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Lane selection followed by extension per op.
  always_comb begin
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    data_o = '0;
    case (op_i)
      OP_LW:   data_o = rdata_i;
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0000, half_sel};
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h000000, byte_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: M pipeline stage of the datapath. Holds one instruction
// from E, drives the data-memory port (address, replicated store data,
// byte enables), extracts load data and registers the GRF write-back (W).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   e_*                   - instruction arriving from the E stage
//   stall / flush         - freeze M / replace incoming E with a bubble
//   m_data_*, m_inst_addr - data-memory port and PC of the M instruction
//   w_*                   - registered GRF write-back
//   m_exc                 - address-error exception code (0 = none)
// Config: define DM_ALIGN_CHECK_EN to trap misaligned word/halfword accesses.
module dm_access_unit
  import dm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            e_valid,
  input  logic [OPW-1:0]  e_op,
  input  logic [XLEN-1:0] e_alu_out,
  input  logic [XLEN-1:0] e_rt,
  input  logic [REGW-1:0] e_rd,
  input  logic [XLEN-1:0] e_pc,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] m_data_addr,
  output logic [XLEN-1:0] m_data_wdata,
  output logic [BEW-1:0]  m_data_byteen,
  output logic [XLEN-1:0] m_inst_addr,
  input  logic [XLEN-1:0] m_data_rdata,
  output logic            w_grf_we,
  output logic [REGW-1:0] w_grf_addr,
  output logic [XLEN-1:0] w_grf_wdata,
  output logic [XLEN-1:0] w_inst_addr,
  output logic [EXCW-1:0] m_exc
);

  m_stage_t        m_q, m_d;
  logic            misal;
  logic [BEW-1:0]  be_raw;
  logic [XLEN-1:0] ext_data;

  logic            w_we_q, w_we_d;
  logic [REGW-1:0] w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_wdata_q, w_wdata_d;
  logic [XLEN-1:0] w_pc_q, w_pc_d;

  // M next state: hold on stall, bubble on flush, else take E.
  always_comb begin
    m_d = m_q;
    if (!stall) begin
      if (flush) begin
        m_d = '0;
      end else begin
        m_d.valid   = e_valid;
        m_d.op      = e_op;
        m_d.alu_out = e_alu_out;
        m_d.rt      = e_rt;
        m_d.rd      = e_rd;
        m_d.pc      = e_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) m_q <= '0;
    else       m_q <= m_d;
  end

`ifdef DM_ALIGN_CHECK_EN
  assign misal = m_q.valid & addr_misaligned(m_q.op, m_q.alu_out[1:0]);
  assign m_exc = misal ? (op_is_store(m_q.op) ? EXC_ADES : EXC_ADEL) : EXC_NONE;
`else
  assign misal = 1'b0;
  assign m_exc = EXC_NONE;
`endif

  assign m_data_addr = m_q.alu_out;
  assign m_inst_addr = m_q.pc;

  // Raw lane enables and replicated store data for the op in M.
  always_comb begin
    be_raw       = '0;
    m_data_wdata = '0;
    case (m_q.op)
      OP_SW: begin
        be_raw       = 4'b1111;
        m_data_wdata = m_q.rt;
      end
      OP_SH: begin
        be_raw       = m_q.alu_out[1] ? 4'b1100 : 4'b0011;
        m_data_wdata = {2{m_q.rt[15:0]}};
      end
      OP_SB: begin
        be_raw       = 4'b0001 << m_q.alu_out[1:0];
        m_data_wdata = {4{m_q.rt[7:0]}};
      end
      default: ;
    endcase
  end

  // Enables are live only in a cycle that ends in a non-stalled, non-reset
  // edge, so a store commits exactly once.
  assign m_data_byteen = (reset || stall || !m_q.valid || misal) ? '0 : be_raw;

  dm_ext u_ext (
    .op_i    (m_q.op),
    .addr_i  (m_q.alu_out[1:0]),
    .rdata_i (m_data_rdata),
    .data_o  (ext_data)
  );

  // W next state: bubble on stall (payload held), else capture M result.
  always_comb begin
    w_we_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_wdata_d = w_wdata_q;
    w_pc_d    = w_pc_q;
    if (!stall) begin
      w_we_d    = m_q.valid & (op_is_load(m_q.op) | (m_q.op == OP_ALU)) &
                  (m_q.rd != '0) & ~misal;
      w_addr_d  = m_q.rd;
      w_wdata_d = op_is_load(m_q.op) ? ext_data : m_q.alu_out;
      w_pc_d    = m_q.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_we_q    <= 1'b0;
      w_addr_q  <= '0;
      w_wdata_q <= '0;
      w_pc_q    <= '0;
    end else begin
      w_we_q    <= w_we_d;
      w_addr_q  <= w_addr_d;
      w_wdata_q <= w_wdata_d;
      w_pc_q    <= w_pc_d;
    end
  end

  assign w_grf_we    = w_we_q;
  assign w_grf_addr  = w_addr_q;
  assign w_grf_wdata = w_wdata_q;
  assign w_inst_addr = w_pc_q;

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 SHALL have ports: clk input 1, clock; reset input 1, reset, synchronous, active-high.
REQ-002 SHALL have: e_valid in 1, E-stage instruction valid; e_op in 4, memory op code; e_alu_out in 32, address or ALU result; e_rt in 32, store source; e_rd in 5, destination register; e_pc in 32, instruction address.
REQ-003 SHALL have: stall in 1, freeze M stage; flush in 1, kill incoming E instruction.
REQ-004 SHALL have: m_data_addr out 32; m_data_wdata out 32; m_data_byteen out 4; m_inst_addr out 32; m_data_rdata in 32, combinational read of word at m_data_addr.
REQ-005 SHALL have: w_grf_we out 1; w_grf_addr out 5; w_grf_wdata out 32; w_inst_addr out 32; m_exc out 5, exception code (0 = none).

Function
REQ-006 SHALL hold one M register {valid, op, alu_out, rt, rd, pc}, loaded from E at posedge when stall=0.
REQ-007 SHALL load a bubble (valid=0) into M when flush=1 and stall=0; stall=1 SHALL hold M regardless of flush.
REQ-008 SHALL decode ops: NOP, ALU, LW, LH, LHU, LB, LBU, SW, SH, SB; undefined codes SHALL behave as NOP.
REQ-009 SHALL drive m_data_addr = M.alu_out and m_inst_addr = M.pc combinationally.
REQ-010 SHALL generate byteen: SW 1111; SH 0011 when addr[1]=0, else 1100; SB 0001 shifted left by addr[1:0]; all else 0000.
REQ-011 SHALL replicate store data: SW rt; SH {2{rt[15:0]}}; SB {4{rt[7:0]}}; else 0.
REQ-012 SHALL force byteen=0000 while stall=1 or M.valid=0, so each store commits exactly once, at the first posedge with stall=0.
REQ-013 SHALL extract loads from m_data_rdata: LW word; LH/LHU halfword at addr[1]; LB/LBU byte at addr[1:0]; sign-extend LH/LB, zero-extend LHU/LBU.
REQ-014 SHALL register into W at posedge when stall=0: w_grf_we = M.valid and (load or ALU) and rd!=0; w_grf_wdata = extended load data or M.alu_out for ALU; w_grf_addr = M.rd; w_inst_addr = M.pc.
REQ-015 SHALL load W with we=0 (bubble) at posedge when stall=1; w_grf_addr/wdata/inst_addr hold previous values.
REQ-016 Latency: instruction captured into M at edge N SHALL write memory and appear on W outputs after edge N+1 (no stall).

Reset
REQ-017 On reset=1 at posedge, M and W SHALL become bubbles; all outputs 0 (byteen 0000, m_exc 0, addresses 0), overriding stall and flush.
REQ-018 Reset mid-store SHALL suppress byteen from the reset edge onward; no partial commit afterwards.

Configuration
REQ-019 Macro DM_ALIGN_CHECK_EN defined: misaligned LW/SW (addr[1:0]!=0) or LH/LHU/SH (addr[0]!=0) SHALL force byteen=0000, w_grf_we=0, m_exc=4 for loads, 5 for stores, held while M holds the instruction.
REQ-020 Macro undefined: m_exc SHALL be tied 0; low address bits not used for lane selection SHALL be ignored.

Structure
REQ-021 Shared package dm_pkg SHALL hold the op encodings and exception codes (EXC_ADEL=4, EXC_ADES=5).
REQ-022 Load extraction and extension SHALL be sub-module dm_ext (inputs op, addr[1:0], rdata; output 32-bit data), purely combinational.

Verification
REQ-023 SB rt=0x000000AB, addr=0x00000006 -> byteen 0100, wdata 0xABABABAB, one commit.
REQ-024 Memory word 0x8081F0FF at 0x10: LB addr 0x11 -> 0xFFFFFFF0; LBU addr 0x11 -> 0x000000F0; LH addr 0x12 -> 0xFFFF8081; LHU addr 0x12 -> 0x00008081.
REQ-025 SW held by stall=1 for 3 cycles -> byteen 0000 during stall, one write after release, W bubble during stall.
REQ-026 flush=1 with an SW on E -> no byteen in the next cycle; stall and flush together -> M unchanged.
REQ-027 LW rd=0 -> w_grf_we=0; ALU rd=5, alu_out 0x1234 -> w_grf_we=1, wdata 0x00001234 one edge after M.
REQ-028 With DM_ALIGN_CHECK_EN: SH addr 0x3 -> byteen 0000, m_exc=5; LW addr 0x2 -> m_exc=4, w_grf_we=0.
